// File: rtl/button_load_pulser_pkg.sv
// Shared state codes and board-clock defaults for the pushbutton conditioning stage.
// Build option: BUTTON_LOAD_PULSER_AUTO_REPEAT_EN enables auto-repeat pulses while held.
package button_load_pulser_pkg;

  localparam logic [2:0] ST_IDLE        = 3'd0;
  localparam logic [2:0] ST_ARM_PRESS   = 3'd1;
  localparam logic [2:0] ST_PULSE       = 3'd2;
  localparam logic [2:0] ST_HELD        = 3'd3;
  localparam logic [2:0] ST_ARM_RELEASE = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE        = ST_IDLE,
    S_ARM_PRESS   = ST_ARM_PRESS,
    S_PULSE       = ST_PULSE,
    S_HELD        = ST_HELD,
    S_ARM_RELEASE = ST_ARM_RELEASE
  } state_t;

  // 1 ms debounce and 0.5 s repeat at the 50 MHz board clock
  localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;
  localparam int DEFAULT_REPEAT_CYCLES   = 25000000;

endpackage

// File: rtl/button_load_pulser_sync.sv
// sync_2ff: generic two-flop synchroniser with a selectable reset level.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_sync1;
  logic r_sync2;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= RST_VAL;
      r_sync2 <= RST_VAL;
    end else begin
      r_sync1 <= i_d;
      r_sync2 <= r_sync1;
    end
  end

  assign o_q = r_sync2;

endmodule

// File: rtl/button_load_pulser.sv
// Synchronises and debounces a raw pushbutton, emitting one load strobe per accepted press.
// Build option: BUTTON_LOAD_PULSER_AUTO_REPEAT_EN adds repeat strobes while the button is held.
module button_load_pulser
  import button_load_pulser_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter bit BTN_ACTIVE_LOW  = 1'b1,
  parameter int REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_clean,
  output logic load_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 1) begin : g_bad_param
    $error("button_load_pulser: DEBOUNCE_CYCLES must be >= 2 and REPEAT_CYCLES >= 1");
  end

  logic          w_sync;
  logic          w_pressed;
  state_t        r_state;
  logic [CW-1:0] r_cnt;

  // Synchroniser resets to the released level so reset never looks like a press
  sync_2ff #(
    .RST_VAL (BTN_ACTIVE_LOW)
  ) u_sync (
    .i_clk (clk),
    .i_rst (rst),
    .i_d   (btn_raw),
    .o_q   (w_sync)
  );

  assign w_pressed = BTN_ACTIVE_LOW ? ~w_sync : w_sync;

`ifdef BUTTON_LOAD_PULSER_AUTO_REPEAT_EN
  localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RW-1:0] REP_MAX = RW'(REPEAT_CYCLES - 1);
  logic [RW-1:0] r_rep_cnt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
`ifdef BUTTON_LOAD_PULSER_AUTO_REPEAT_EN
      r_rep_cnt <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_pressed) r_state <= S_ARM_PRESS;
        end
        S_ARM_PRESS: begin
          if (!w_pressed) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_MAX) begin
            r_state <= S_PULSE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_PULSE: begin
          r_state <= S_HELD;
          r_cnt   <= '0;
`ifdef BUTTON_LOAD_PULSER_AUTO_REPEAT_EN
          r_rep_cnt <= '0;
`endif
        end
        S_HELD: begin
          if (!w_pressed) begin
            r_state <= S_ARM_RELEASE;
            r_cnt   <= '0;
          end
`ifdef BUTTON_LOAD_PULSER_AUTO_REPEAT_EN
          else if (r_rep_cnt == REP_MAX) begin
            r_state <= S_PULSE;
          end else begin
            r_rep_cnt <= r_rep_cnt + 1'b1;
          end
`endif
        end
        S_ARM_RELEASE: begin
          // A pressed sample cancels the release without producing another strobe
          if (w_pressed) begin
            r_state <= S_HELD;
            r_cnt   <= '0;
`ifdef BUTTON_LOAD_PULSER_AUTO_REPEAT_EN
            r_rep_cnt <= '0;
`endif
          end else if (r_cnt == CNT_MAX) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign load_pulse = (r_state == S_PULSE);
  assign btn_clean  = (r_state == S_PULSE) || (r_state == S_HELD) ||
                      (r_state == S_ARM_RELEASE);

endmodule

// File: tb/tb_button_load_pulser.sv
// Directed per-edge vector table for button_load_pulser (debounce 4, repeat 8, active-low).
module tb_button_load_pulser;

  localparam int NV = 200;

  logic clk;
  logic rst;
  logic btn_raw;
  logic btn_clean;
  logic load_pulse;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic rst;
    logic raw;
    logic exp_pulse;
    logic exp_clean;
  } vec_t;

  vec_t vec[NV];

  button_load_pulser #(
    .DEBOUNCE_CYCLES (4),
    .BTN_ACTIVE_LOW  (1'b1),
    .REPEAT_CYCLES   (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .btn_clean  (btn_clean),
    .load_pulse (load_pulse)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_raw(input int a, input int b, input logic v);
    for (int i = a; i <= b; i++) vec[i].raw = v;
  endtask

  task automatic set_clean(input int a, input int b);
    for (int i = a; i <= b; i++) vec[i].exp_clean = 1'b1;
  endtask

  task automatic check(input string name, input int idx, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %b expected %b", name, idx, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    rst     = 1'b1;
    btn_raw = 1'b1;

    for (int i = 0; i < NV; i++) vec[i] = '{rst: 1'b0, raw: 1'b1, exp_pulse: 1'b0, exp_clean: 1'b0};

    // Button pressed through reset: re-qualified from IDLE after rst falls
    for (int i = 0; i <= 2; i++) vec[i].rst = 1'b1;
    set_raw(0, 11, 1'b0);
    vec[9].exp_pulse = 1'b1;
    set_clean(9, 17);

    // Clean press and release
    set_raw(30, 41, 1'b0);
    vec[36].exp_pulse = 1'b1;
    set_clean(36, 47);

    // Press bounce 0,0,1 x3 then steady
    set_raw(60, 61, 1'b0);
    set_raw(63, 64, 1'b0);
    set_raw(66, 67, 1'b0);
    set_raw(69, 80, 1'b0);
    vec[75].exp_pulse = 1'b1;
    set_clean(75, 86);

    // Release bounce: two released samples then pressed again
    set_raw(90, 99, 1'b0);
    set_raw(102, 104, 1'b0);
    vec[96].exp_pulse = 1'b1;
    set_clean(96, 110);

    // Reset pulse in the middle of press qualification
    set_raw(120, 135, 1'b0);
    vec[124].rst = 1'b1;
    vec[131].exp_pulse = 1'b1;
    set_clean(131, 141);

    // Long hold: repeat strobes only when the auto-repeat build is selected
    set_raw(150, 186, 1'b0);
    vec[156].exp_pulse = 1'b1;
`ifdef BUTTON_LOAD_PULSER_AUTO_REPEAT_EN
    vec[165].exp_pulse = 1'b1;
    vec[174].exp_pulse = 1'b1;
    vec[183].exp_pulse = 1'b1;
`endif
    set_clean(156, 192);

    // Apply vectors: inputs settle before edge i, outputs checked just after it
    for (int i = 0; i < NV; i++) begin
      rst     = vec[i].rst;
      btn_raw = vec[i].raw;
      tick();
      check("load_pulse", i, load_pulse, vec[i].exp_pulse);
      check("btn_clean", i, btn_clean, vec[i].exp_clean);
    end

    // Press latency measured with a bounded wait: sampled at wait edge 1, strobe after edge 7
    rst     = 1'b0;
    btn_raw = 1'b0;
    lat     = 0;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (load_pulse === 1'b1) begin
        lat = c;
        break;
      end
    end
    checks++;
    if (lat != 7) begin
      errors++;
      $display("FAIL press_latency: got %0d edges expected 7 (0 = timeout)", lat);
    end
    tick();
    check("pulse_one_cycle", lat + 1, load_pulse, 1'b0);
    check("clean_held", lat + 1, btn_clean, 1'b1);

    // Reset while held drops the clean level at that edge
    rst = 1'b1;
    tick();
    check("rst_held_clean", 0, btn_clean, 1'b0);
    check("rst_held_pulse", 0, load_pulse, 1'b0);
    rst     = 1'b0;
    btn_raw = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("idle_after_rst_pulse", c, load_pulse, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
